// File: rtl/or1k_store_drain.sv
// or1k_store_drain: pops one store at a time from the CPU store buffer and
// writes it out as a single Wishbone write cycle. It resolves atomic (l.swa)
// stores against the LSU reservation and guards each bus cycle with an ack
// watchdog. It also reports bus errors and timeouts with the PC of the
// faulting store.
module or1k_store_drain #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int TIMEOUT_WIDTH        = 8,
  parameter int TIMEOUT_CYCLES       = 255
) (
  input  logic                              clk,
  input  logic                              rst,

  input  logic                              sb_empty_i,
  output logic                              sb_read_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_dat_i,
  input  logic [OPTION_OPERAND_WIDTH/8-1:0] sb_bsel_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_pc_i,
  input  logic                              sb_atomic_i,

  input  logic                              atomic_rsv_i,
  input  logic                              hold_i,

  output logic [OPTION_OPERAND_WIDTH-1:0]   wbm_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   wbm_dat_o,
  output logic [OPTION_OPERAND_WIDTH/8-1:0] wbm_sel_o,
  output logic                              wbm_cyc_o,
  output logic                              wbm_stb_o,
  output logic                              wbm_we_o,
  input  logic                              wbm_ack_i,
  input  logic                              wbm_err_i,

  output logic                              atomic_done_o,
  output logic                              atomic_ok_o,
  output logic                              store_err_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   err_pc_o,
  output logic                              busy_o
);

  localparam int OW = OPTION_OPERAND_WIDTH;
  localparam int SW = OPTION_OPERAND_WIDTH / 8;

  // Watchdog fires in the BUS cycle whose count of elapsed BUS cycles equals
  // TIMEOUT_CYCLES-1, so cyc_o stays high for exactly TIMEOUT_CYCLES cycles.
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST =
    WD_EN ? TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_POP   = 2'd1,
    S_LATCH = 2'd2,
    S_BUS   = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     done_q, done_d;
  logic                     ok_q, ok_d;
  logic                     err_q, err_d;
  logic [OW-1:0]            err_pc_q, err_pc_d;

  // Latched store entry; only meaningful while in BUS, so never reset.
  logic [OW-1:0]            adr_q;
  logic [OW-1:0]            dat_q;
  logic [SW-1:0]            sel_q;
  logic [OW-1:0]            pc_q;
  logic                     atomic_q;

  logic                     latch_en;
  logic                     in_bus;
  logic                     timeout;

  // Saturating increment keeps the watchdog from wrapping back to zero.
  function automatic logic [TIMEOUT_WIDTH-1:0] sat_inc(
    input logic [TIMEOUT_WIDTH-1:0] v
  );
    if (v == {TIMEOUT_WIDTH{1'b1}}) return v;
    return v + 1'b1;
  endfunction

  // Next-state and pulse generation for the drain FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    done_d   = 1'b0;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    err_pc_d = err_pc_q;
    latch_en = 1'b0;
    timeout  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // hold_i wins over a non-empty buffer: the LSU owns the bus.
        if (!sb_empty_i && !hold_i) state_d = S_POP;
      end

      S_POP: begin
        state_d = S_LATCH;
      end

      S_LATCH: begin
        latch_en = 1'b1;
        if (sb_atomic_i && !atomic_rsv_i) begin
          // Reservation lost: the conditional store is dropped without a bus cycle.
          done_d  = 1'b1;
          ok_d    = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_BUS;
        end
      end

      S_BUS: begin
        timeout = WD_EN && (cnt_q == TO_LAST);
        cnt_d   = sat_inc(cnt_q);
        if (wbm_err_i || (!wbm_ack_i && timeout)) begin
          // Error beats ack; ack beats timeout. Errored stores are discarded.
          err_d    = 1'b1;
          err_pc_d = pc_q;
          done_d   = atomic_q;
          ok_d     = 1'b0;
          cnt_d    = '0;
          state_d  = S_IDLE;
        end else if (wbm_ack_i) begin
          done_d  = atomic_q;
          ok_d    = atomic_q;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state, watchdog and registered status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      err_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      err_pc_q <= err_pc_d;
    end
  end

  // Capture the popped entry the cycle after the pop strobe.
  always_ff @(posedge clk) begin
    if (latch_en) begin
      adr_q    <= sb_adr_i;
      dat_q    <= sb_dat_i;
      sel_q    <= sb_bsel_i;
      pc_q     <= sb_pc_i;
      atomic_q <= sb_atomic_i;
    end
  end

  assign in_bus = (state_q == S_BUS);

  assign sb_read_o     = (state_q == S_POP);
  assign wbm_cyc_o     = in_bus;
  assign wbm_stb_o     = in_bus;
  assign wbm_we_o      = in_bus;
  // Address/data/select are forced to zero outside BUS so reset shows all-zero outputs.
  assign wbm_adr_o     = in_bus ? adr_q : '0;
  assign wbm_dat_o     = in_bus ? dat_q : '0;
  assign wbm_sel_o     = in_bus ? sel_q : '0;
  assign atomic_done_o = done_q;
  assign atomic_ok_o   = ok_q;
  assign store_err_o   = err_q;
  assign err_pc_o      = err_pc_q;
  assign busy_o        = (state_q != S_IDLE) || !sb_empty_i;

endmodule

// File: tb/tb_or1k_store_drain.sv
// Testbench for or1k_store_drain: a store-buffer model and a Wishbone slave
// model react to the DUT, and a scoreboard monitor compares observed bus cycles
// and status pulses against expectations queued when each store is issued.
module tb_or1k_store_drain;

  localparam int TB_TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sb_empty_i;
  logic        sb_read_o;
  logic [31:0] sb_adr_i;
  logic [31:0] sb_dat_i;
  logic [3:0]  sb_bsel_i;
  logic [31:0] sb_pc_i;
  logic        sb_atomic_i;
  logic        atomic_rsv_i;
  logic        hold_i;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic        atomic_done_o;
  logic        atomic_ok_o;
  logic        store_err_o;
  logic [31:0] err_pc_o;
  logic        busy_o;

  always #5 clk = ~clk;

  or1k_store_drain #(
    .OPTION_OPERAND_WIDTH(32),
    .TIMEOUT_WIDTH(8),
    .TIMEOUT_CYCLES(TB_TO)
  ) dut (
    .clk(clk), .rst(rst),
    .sb_empty_i(sb_empty_i), .sb_read_o(sb_read_o),
    .sb_adr_i(sb_adr_i), .sb_dat_i(sb_dat_i), .sb_bsel_i(sb_bsel_i),
    .sb_pc_i(sb_pc_i), .sb_atomic_i(sb_atomic_i),
    .atomic_rsv_i(atomic_rsv_i), .hold_i(hold_i),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .atomic_done_o(atomic_done_o), .atomic_ok_o(atomic_ok_o),
    .store_err_o(store_err_o), .err_pc_o(err_pc_o), .busy_o(busy_o)
  );

  // Slave response kinds carried with each entry.
  localparam int R_ACK  = 0;
  localparam int R_ERR  = 1;
  localparam int R_NONE = 2;

  // Scoreboard event kinds.
  localparam int E_BUS  = 0;
  localparam int E_END  = 1;
  localparam int E_ATOM = 2;
  localparam int E_ERR  = 3;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] pc;
    logic [3:0]  sel;
    logic        atomic;
    int          kind;
    int          wt;
  } ent_t;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } ev_t;

  ent_t sbq[$];
  ev_t  expq[$];
  int   bus_starts[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_cnt = 0;
  int   pops = 0;
  int   pushed = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    ev_t e;
    e.kind = kind; e.a = a; e.d = d; e.s = s;
    expq.push_back(e);
  endtask

  // Queue a store in the buffer model and predict every observable event for it.
  task automatic push_store(input logic [31:0] adr, input logic [31:0] dat,
                            input logic [31:0] pc, input logic [3:0] sel,
                            input logic atomic, input int kind, input int wt);
    ent_t e;
    e.adr = adr; e.dat = dat; e.pc = pc; e.sel = sel;
    e.atomic = atomic; e.kind = kind; e.wt = wt;
    if (atomic && !atomic_rsv_i) begin
      push_ev(E_ATOM, 32'd0, 32'd0, 4'd0);
    end else begin
      push_ev(E_BUS, adr, dat, sel);
      push_ev(E_END, (kind == R_NONE) ? TB_TO : wt + 1, 32'd0, 4'd0);
      if (kind == R_ACK) begin
        if (atomic) push_ev(E_ATOM, 32'd1, 32'd0, 4'd0);
      end else begin
        if (atomic) push_ev(E_ATOM, 32'd0, 32'd0, 4'd0);
        push_ev(E_ERR, pc, 32'd0, 4'd0);
      end
    end
    sbq.push_back(e);
    pushed++;
    sb_empty_i = (sbq.size() == 0);
  endtask

  task automatic ev_check(input int kind, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    ev_t e;
    if (expq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event actual_kind=%0d actual_a=%0h required=none", kind, a);
    end else begin
      e = expq.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind == e.kind) begin
        case (kind)
          E_BUS: begin
            chk("bus_adr", a, e.a);
            chk("bus_dat", d, e.d);
            chk("bus_sel", s, e.s);
          end
          E_END:   chk("bus_len", a, e.a);
          E_ATOM:  chk("atomic_ok", a, e.a);
          default: chk("err_pc", a, e.a);
        endcase
      end
    end
  endtask

  // Store-buffer and Wishbone-slave models, driven mid-cycle.
  initial begin
    int bcnt;
    int ck;
    int cw;
    ent_t e;
    bcnt = 0; ck = R_ACK; cw = 0;
    sb_empty_i = 1'b1; sb_adr_i = '0; sb_dat_i = '0; sb_bsel_i = '0;
    sb_pc_i = '0; sb_atomic_i = 1'b0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    forever begin
      @(negedge clk);
      if (sb_read_o && sbq.size() > 0) begin
        e = sbq.pop_front();
        sb_adr_i = e.adr; sb_dat_i = e.dat; sb_bsel_i = e.sel;
        sb_pc_i = e.pc; sb_atomic_i = e.atomic;
        ck = e.kind; cw = e.wt;
      end
      sb_empty_i = (sbq.size() == 0);
      if (wbm_cyc_o && wbm_stb_o) begin
        bcnt++;
        wbm_ack_i = (ck == R_ACK) && (bcnt == cw + 1);
        wbm_err_i = (ck == R_ERR) && (bcnt == cw + 1);
      end else begin
        bcnt = 0;
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
      end
    end
  end

  // Scoreboard monitor, sampling just after each rising edge.
  initial begin
    logic        prev_cyc;
    int          blen;
    logic [31:0] ba;
    logic [31:0] bd;
    logic [3:0]  bs;
    prev_cyc = 1'b0; blen = 0; ba = '0; bd = '0; bs = '0;
    forever begin
      @(posedge clk);
      cyc_cnt++;
      #1;
      if (sb_read_o) begin
        pops++;
        chk("pop_while_empty", sb_empty_i, 1'b0);
      end
      if (wbm_cyc_o) begin
        chk("stb_we_with_cyc", {wbm_stb_o, wbm_we_o}, 2'b11);
        if (!prev_cyc) begin
          blen = 1;
          ba = wbm_adr_o; bd = wbm_dat_o; bs = wbm_sel_o;
          bus_starts.push_back(cyc_cnt);
          ev_check(E_BUS, wbm_adr_o, wbm_dat_o, wbm_sel_o);
        end else begin
          blen++;
          chk("bus_stable", {wbm_adr_o, wbm_dat_o, wbm_sel_o}, {ba, bd, bs});
        end
      end else if (prev_cyc) begin
        ev_check(E_END, blen, 32'd0, 4'd0);
      end
      if (atomic_done_o) ev_check(E_ATOM, {31'd0, atomic_ok_o}, 32'd0, 4'd0);
      if (store_err_o)   ev_check(E_ERR, err_pc_o, 32'd0, 4'd0);
      prev_cyc = wbm_cyc_o;
    end
  end

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sbq.size() != 0 || busy_o || expq.size() != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, (n < 200), 1'b1);
  endtask

  // Directed test sequence.
  initial begin
    int t0;
    int p0;
    bit found;
    rst = 1'b1; hold_i = 1'b0; atomic_rsv_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sb_read", sb_read_o, 1'b0);
    chk("rst_cyc_stb_we", {wbm_cyc_o, wbm_stb_o, wbm_we_o}, 3'b000);
    chk("rst_bus_vals", {wbm_adr_o, wbm_dat_o, wbm_sel_o}, 68'd0);
    chk("rst_pulses", {atomic_done_o, atomic_ok_o, store_err_o}, 3'b000);
    chk("rst_err_pc", err_pc_o, 32'd0);
    chk("rst_busy", busy_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single store, ack on the third BUS cycle.
    bus_starts.delete();
    t0 = cyc_cnt; p0 = pops;
    push_store(32'h100, 32'hDEADBEEF, 32'h1000, 4'hF, 1'b0, R_ACK, 2);
    wait_drain("t1_drain");
    chk("t1_pops", pops - p0, 1);
    chk("t1_nstarts", bus_starts.size(), 1);
    if (bus_starts.size() >= 1) chk("t1_latency", bus_starts[0] - t0, 3);
    chk("t1_busy_low", busy_o, 1'b0);

    // Three queued stores, zero-wait acks: FIFO order at 4-cycle spacing.
    @(negedge clk);
    bus_starts.delete();
    t0 = cyc_cnt; p0 = pops;
    push_store(32'h200, 32'h11111111, 32'h1100, 4'h3, 1'b0, R_ACK, 0);
    push_store(32'h204, 32'h22222222, 32'h1104, 4'hC, 1'b0, R_ACK, 0);
    push_store(32'h208, 32'h33333333, 32'h1108, 4'hF, 1'b0, R_ACK, 0);
    wait_drain("t2_drain");
    chk("t2_pops", pops - p0, 3);
    chk("t2_nstarts", bus_starts.size(), 3);
    if (bus_starts.size() >= 3) begin
      chk("t2_latency", bus_starts[0] - t0, 3);
      chk("t2_spacing_01", bus_starts[1] - bus_starts[0], 4);
      chk("t2_spacing_12", bus_starts[2] - bus_starts[1], 4);
    end

    // Atomic store with lost reservation: popped, no bus cycle, done/!ok.
    @(negedge clk);
    bus_starts.delete();
    atomic_rsv_i = 1'b0; p0 = pops;
    push_store(32'h300, 32'hAAAA5555, 32'h1200, 4'hF, 1'b1, R_ACK, 0);
    wait_drain("t3_drain");
    chk("t3_pops", pops - p0, 1);
    chk("t3_no_bus", bus_starts.size(), 0);

    // Atomic store with valid reservation: written, done/ok.
    @(negedge clk);
    atomic_rsv_i = 1'b1;
    push_store(32'h304, 32'h5555AAAA, 32'h1204, 4'hF, 1'b1, R_ACK, 1);
    wait_drain("t4_drain");
    atomic_rsv_i = 1'b0;

    // Bus error on pc 0x2004, then a normal store; error PC must be held.
    @(negedge clk);
    push_store(32'h400, 32'h44444444, 32'h2004, 4'hF, 1'b0, R_ERR, 0);
    push_store(32'h404, 32'h45454545, 32'h2008, 4'h1, 1'b0, R_ACK, 0);
    wait_drain("t5_drain");
    chk("t5_err_pc_held", err_pc_o, 32'h2004);

    // hold_i in IDLE blocks the pop even with a non-empty buffer.
    @(negedge clk);
    hold_i = 1'b1; p0 = pops;
    push_store(32'h500, 32'h50505050, 32'h2100, 4'hF, 1'b0, R_ACK, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("hold_no_pop", pops - p0, 0);
    chk("hold_busy", busy_o, 1'b1);
    @(negedge clk);
    hold_i = 1'b0;
    wait_drain("hold_drain");
    chk("hold_pop_after", pops - p0, 1);

    // No ack: watchdog ends the cycle after TB_TO BUS cycles.
    @(negedge clk);
    push_store(32'h600, 32'h66666666, 32'h3000, 4'hF, 1'b0, R_NONE, 0);
    wait_drain("t6_drain");
    chk("t6_err_pc", err_pc_o, 32'h3000);

    // Reset during the second BUS cycle drops cyc_o at the next edge.
    @(negedge clk);
    push_store(32'h700, 32'h77777777, 32'h3100, 4'hF, 1'b0, R_NONE, 0);
    void'(expq.pop_back());
    void'(expq.pop_back());
    push_ev(E_END, 32'd2, 32'd0, 4'd0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (wbm_cyc_o) begin
        found = 1'b1;
        break;
      end
    end
    chk("t7_bus_seen", found, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t7_cyc_dropped", {wbm_cyc_o, wbm_stb_o}, 2'b00);
    chk("t7_err_pc_reset", err_pc_o, 32'd0);
    chk("t7_no_err_pulse", store_err_o, 1'b0);
    chk("t7_busy_low", busy_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("final_exp_empty", expq.size(), 0);
    chk("final_pops", pops, pushed);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
